// File: rtl/dmem_port_arbiter_if.sv
// Bundle between the two requesters, the data memory and the arbiter.
// With ARB_LOCK_EN the bundle also carries lock0/lock1.
interface dmem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
`ifdef ARB_LOCK_EN
  logic          lock0;
  logic          lock1;
`endif
  logic          gnt0;
  logic          gnt1;
  logic          done0;
  logic          done1;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;
  logic          busy;

`ifdef ARB_LOCK_EN
  modport master (
    output req0, req1, we0, we1,
    output addr0, addr1, wdata0, wdata1,
    output lock0, lock1, mem_rdata,
    input  gnt0, gnt1, done0, done1,
    input  rdata0, rdata1, busy,
    input  mem_addr, mem_wdata, mem_we
  );
  modport slave (
    input  req0, req1, we0, we1,
    input  addr0, addr1, wdata0, wdata1,
    input  lock0, lock1, mem_rdata,
    output gnt0, gnt1, done0, done1,
    output rdata0, rdata1, busy,
    output mem_addr, mem_wdata, mem_we
  );
`else
  modport master (
    output req0, req1, we0, we1,
    output addr0, addr1, wdata0, wdata1,
    output mem_rdata,
    input  gnt0, gnt1, done0, done1,
    input  rdata0, rdata1, busy,
    input  mem_addr, mem_wdata, mem_we
  );
  modport slave (
    input  req0, req1, we0, we1,
    input  addr0, addr1, wdata0, wdata1,
    input  mem_rdata,
    output gnt0, gnt1, done0, done1,
    output rdata0, rdata1, busy,
    output mem_addr, mem_wdata, mem_we
  );
`endif
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin owner of the data-memory port: CPU on port 0, DMA on port 1.
// Define ARB_LOCK_EN for lock0/lock1 bursts of up to MAX_BURST grants.
module dmem_port_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int RD_LAT    = 1
`ifdef ARB_LOCK_EN
  ,
  parameter int MAX_BURST = 4
`endif
) (
  input logic                clk_i,
  input logic                rst_i,
  dmem_port_arbiter_if.slave bus
);
  localparam int CW = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {
    IDLE, ACCESS, WAIT, DONE
  } state_e;

  state_e        state_q, state_d;
  logic          last_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata0_q;
  logic [DW-1:0] rdata1_q;
  logic [CW-1:0] cnt_q;
  logic          any_req;
  logic          grant;
  logic          win;
  logic          rd_cap;

  assign any_req = bus.req0 | bus.req1;
  assign grant   = (state_q == IDLE) & any_req;
  assign rd_cap  = (state_q == WAIT) & (cnt_q == CW'(1));

`ifdef ARB_LOCK_EN
  localparam int BW = $clog2(MAX_BURST + 1);

  logic          force_q;
  logic [BW-1:0] burst_q;
  logic          own_lock;
  logic          lock_hit;

  // last_q doubles as the current owner while a transaction runs
  assign own_lock = last_q ? bus.lock1 : bus.lock0;
  assign lock_hit = force_q & (last_q ? bus.req1 : bus.req0);
`endif

  always_comb begin
    win = ~last_q;
    if (bus.req0 ^ bus.req1) win = bus.req1;
`ifdef ARB_LOCK_EN
    if (lock_hit) win = last_q;
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  state_d = we_q ? DONE : WAIT;
      WAIT:    if (rd_cap) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (grant) begin
        last_q  <= win;
        we_q    <= win ? bus.we1 : bus.we0;
        addr_q  <= win ? bus.addr1 : bus.addr0;
        wdata_q <= win ? bus.wdata1 : bus.wdata0;
      end
      if (state_q == ACCESS)    cnt_q <= CW'(RD_LAT);
      else if (state_q == WAIT) cnt_q <= cnt_q - CW'(1);
      if (rd_cap & ~last_q) rdata0_q <= bus.mem_rdata;
      if (rd_cap & last_q)  rdata1_q <= bus.mem_rdata;
    end
  end

`ifdef ARB_LOCK_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      force_q <= 1'b0;
      burst_q <= '0;
    end else if (grant) begin
      force_q <= 1'b0;
      burst_q <= lock_hit ? burst_q + BW'(1) : BW'(1);
    end else if (state_q == DONE) begin
      force_q <= own_lock & (burst_q < BW'(MAX_BURST));
    end
  end
`endif

  always_comb begin
    bus.busy      = state_q != IDLE;
    bus.gnt0      = (state_q != IDLE) & ~last_q;
    bus.gnt1      = (state_q != IDLE) & last_q;
    bus.done0     = (state_q == DONE) & ~last_q;
    bus.done1     = (state_q == DONE) & last_q;
    bus.mem_we    = (state_q == ACCESS) & we_q;
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
    bus.rdata0    = rdata0_q;
    bus.rdata1    = rdata1_q;
  end
endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port between two requesters: port 0 is the CPU load/store path, port 1 is a DMA/loader or I/O engine.
- Round-robin grant FSM.
- Drives the memory's address, write-data and write-enable.
- Waits a fixed synchronous-read latency, then returns read data with a one-cycle done pulse.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- RD_LAT, 1, number of cycles from address presented to mem_rdata valid; legal range 1..4.
- MAX_BURST, 4, maximum number of consecutive locked grants (used only with ARB_LOCK_EN).

Ports:
- clock  in  1  single system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0/req1  in  1  access request, held until matching done.
- we0/we1  in  1  1=write, 0=read; stable while req high.
- addr0/addr1  in  AW  access address.
- wdata0/wdata1  in  DW  write data.
- gnt0/gnt1  out  1  high while this port owns the memory (ACCESS/WAIT/DONE).
- done0/done1  out  1  one-cycle completion pulse.
- rdata0/rdata1  out  DW  read data, valid from done pulse onward.
- mem_addr  out  AW  address to data memory.
- mem_wdata  out  DW  write data to data memory.
- mem_we  out  1  write strobe, exactly one cycle per write.
- mem_rdata  in  DW  memory read data.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, last=1 (port0 wins first tie).
  - All outputs 0, including rdata0/rdata1, mem_addr, mem_wdata.
  - Reset mid-transaction aborts it: no done pulse, mem_we drops immediately.
- States: IDLE, ACCESS, WAIT, DONE.
- IDLE: sample req0/req1 at the edge.
  - None: stay.
  - One: grant it.
  - Both: grant the port != last.
  - On a grant: latch addr/wdata/we of the winner into mem_addr/mem_wdata/op, set last=winner, go to ACCESS.
- ACCESS (1 cycle):
  - gnt_x=1; mem_we=1 iff write.
  - Write → DONE.
  - Read → WAIT with counter=RD_LAT.
- WAIT:
  - Decrement counter each cycle.
  - In the cycle the counter reaches 1, capture mem_rdata into rdata_x at the edge and go to DONE.
  - mem_addr held stable throughout.
- DONE (1 cycle): done_x=1, gnt_x still 1, → IDLE.
- Latency from the request-sampling edge (IDLE cycle t0):
  - Write: done in t2.
  - Read: done in t(2+RD_LAT), i.e. t3 for RD_LAT=1.
- Throughput: a new grant is possible in the IDLE cycle after DONE.
- Worst case: a port waits one full foreign transaction before being granted.
- Request handling:
  - A request still high in IDLE after its own DONE is treated as a new request.
  - Requesters must drop req in the cycle after done.
  - A req deasserted mid-transaction does not cancel it; done still pulses.
- rdata_x holds until the next read completes on the same port.
- Writes never modify rdata_x.
- The non-granted port's gnt/done stay 0.
- mem_we is never asserted outside ACCESS.
- Fairness: both ports requesting continuously are granted strictly alternately.

Optional Feature:
- Macro: ARB_LOCK_EN.
- When defined:
  - Adds inputs lock0/lock1 (1 bit each).
  - If lock_x is high during DONE, port x wins the next IDLE arbitration regardless of the other request and of last.
  - A burst counter limits this to MAX_BURST consecutive grants; the next arbitration then uses normal round-robin with last=x, so the other port wins if requesting.
  - The counter clears on any non-locked grant or on a grant to the other port.
- When undefined: no lock ports, pure round-robin as above.

Test Plan:
- Single write: req0=1, we0=1, addr0=0x10, wdata0=0xDEADBEEF at t0 → mem_we=1 only in t1 with mem_addr=0x10, done0=1 in t2, busy low in t3.
- Single read, RD_LAT=1: memory returns 0x1234 for addr1=0x20 → done1 in t3, rdata1=0x1234, rdata0 unchanged.
- Simultaneous requests after reset: req0 and req1 both high → port0 granted first, port1 granted in the IDLE after done0; continuous requests alternate 0,1,0,1.
- Reset asserted during WAIT of a read → all outputs 0 immediately, no done pulse; after release, a pending req1 is granted normally.
- RD_LAT=3: read issued → mem_addr stable for 4 cycles (ACCESS + 3 WAIT), done at t5 with the data captured from the last WAIT cycle.
- ARB_LOCK_EN, MAX_BURST=4: port0 locked, both ports requesting continuously → four port0 transactions, then one port1 transaction.
